// File: rtl/alu_shifter_pkg.sv
// Shared definitions for the sequential result shifter: widths, shift op codes, FSM states.
package alu_shifter_pkg;

  localparam int unsigned NBITS = 32;
  localparam int unsigned SHW   = $clog2(NBITS);

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRL  = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  typedef logic [1:0] shifter_state_t;

  localparam shifter_state_t ST_IDLE  = 2'b00;
  localparam shifter_state_t ST_SHIFT = 2'b01;
  localparam shifter_state_t ST_DONE  = 2'b10;

endpackage : alu_shifter_pkg

// File: rtl/alu_shifter_shift_step.sv
// Combinational single-position shifter used on the result register feedback path.
module shift_step
  import alu_shifter_pkg::*;
(
  input  logic [NBITS-1:0] value_i,
  input  logic [1:0]       op_i,
  output logic [NBITS-1:0] shifted_o
);

  always_comb begin
    shifted_o = value_i;
    case (op_i)
      SH_SLL:  shifted_o = {value_i[NBITS-2:0], 1'b0};
      SH_SRL:  shifted_o = {1'b0, value_i[NBITS-1:1]};
      SH_SRA:  shifted_o = {value_i[NBITS-1], value_i[NBITS-1:1]};
      default: shifted_o = value_i;
    endcase
  end

endmodule : shift_step

// File: rtl/alu_shifter.sv
// One-bit-per-clock shifter between the ALU result mux and the C bus, with N/Z flag capture.
module alu_shifter
  import alu_shifter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] y,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  input  logic             start,
  output logic [NBITS-1:0] result,
  output logic             n_flag,
  output logic             z_flag,
  output logic             busy,
  output logic             done
);

  shifter_state_t   state_q, state_d;
  logic [NBITS-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic [NBITS-1:0] step_value;

  shift_step u_shift_step (
    .value_i   (result_q),
    .op_i      (op_q),
    .shifted_o (step_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= SH_PASS;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  // Flags are taken from the value result assumes on the edge that enters DONE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    n_d      = n_q;
    z_d      = z_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          result_d = y;
          cnt_d    = shamt;
          op_d     = op;
          if (op == SH_PASS || shamt == '0) begin
            state_d = ST_DONE;
            n_d     = y[NBITS-1];
            z_d     = (y == '0);
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        result_d = step_value;
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_DONE;
          n_d     = step_value[NBITS-1];
          z_d     = (step_value == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign result = result_q;
  assign n_flag = n_q;
  assign z_flag = z_q;
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);

endmodule : alu_shifter

// File: tb/tb_alu_shifter.sv
// Scoreboard bench for alu_shifter: driver pushes model results, negedge monitor checks each done.
module tb_alu_shifter;
  import alu_shifter_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [NBITS-1:0] y;
  logic [SHW-1:0]   shamt;
  logic [1:0]       op;
  logic             start;
  logic [NBITS-1:0] result;
  logic             n_flag, z_flag, busy, done;

  alu_shifter dut (
    .clk    (clk),
    .reset  (reset),
    .y      (y),
    .shamt  (shamt),
    .op     (op),
    .start  (start),
    .result (result),
    .n_flag (n_flag),
    .z_flag (z_flag),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v, input int s);
    case (o)
      2'b01:   return v << s;
      2'b10:   return v >> s;
      2'b11:   return $unsigned($signed(v) >>> s);
      default: return v;
    endcase
  endfunction

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 result=%h", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("n_flag", 32'(n_flag), 32'(e.res[31]));
        chk("z_flag", 32'(z_flag), 32'(e.res == 32'd0));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] v, input int s);
    exp_t e;
    op    = o;
    y     = v;
    shamt = SHW'(s);
    start = 1'b1;
    e.res = model(o, v, s);
    e.lat = (o == SH_PASS || s == 0) ? 1 : s + 1;
    e.acc = cyc;
    last_res = e.res;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    bit seen = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] v, input int s);
    int nb;
    start_op(o, v, s);
    wait_done(nb);
    chk("busy_cycles", 32'(nb), (o == SH_PASS || s == 0) ? 32'd0 : 32'(s));
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    start = 1'b0;
    y     = '0;
    shamt = '0;
    op    = SH_PASS;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Abort a long SLL with reset; nothing is pushed so any done is flagged.
    op = SH_SLL; y = 32'h0000_00FF; shamt = SHW'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_result", result, 32'd0);
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    chk("abort_flags", {30'd0, n_flag, z_flag}, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);

    run_op(SH_SLL, 32'h0000_0001, 4);
    @(negedge clk);
    run_op(SH_SRA, 32'h8000_0000, 31);
    @(negedge clk);
    run_op(SH_SRL, 32'h8000_0000, 31);
    @(negedge clk);
    run_op(SH_PASS, 32'h0000_0000, 7);
    @(negedge clk);
    run_op(SH_SLL, 32'h1234_5678, 0);
    @(negedge clk);

    // start pulses during SHIFT must be ignored.
    start_op(SH_SRL, 32'hF0F0_0000, 8);
    start = 1'b1; y = $urandom; op = SH_SLL; shamt = SHW'(2);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    chk("ignored_busy", 32'(nb), 32'd6);
    @(negedge clk);

    // Back-to-back: new start in the DONE cycle, then PASS keeps done high a second cycle.
    start_op(SH_SLL, 32'h0000_0003, 3);
    wait_done(nb);
    run_op(SH_SRA, 32'h9000_0000, 5);
    start_op(SH_SLL, 32'h0000_0005, 2);
    wait_done(nb);
    start_op(SH_PASS, 32'hDEAD_BEEF, 9);
    chk("b2b_done_held", 32'(done), 32'd1);
    wait_done(nb);
    @(negedge clk);

    // Flags and result hold while idle with wiggling inputs.
    run_op(SH_SLL, 32'h4000_0000, 1);
    for (int i = 0; i < 6; i++) begin
      y = $urandom; op = 2'($urandom_range(0, 3)); shamt = SHW'($urandom_range(0, 31));
      @(negedge clk);
    end
    chk("hold_result", result, last_res);
    chk("hold_flags", {30'd0, n_flag, z_flag}, {30'd0, last_res[31], last_res == 32'd0});

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] v;
      int          s;
      o = 2'($urandom_range(0, 3));
      v = (i % 5 == 0) ? 32'd0 : $urandom;
      s = (i % 7 == 0) ? 0 : int'($urandom_range(0, 31));
      run_op(o, v, s);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_shifter
